ebr_uart_dumper: RTL
====================

// Module: ebr_uart_dumper
// PURPOSE
//   Drains a window of the 16-bit dual-port EBR (written by the Octal RAM operator) out through
//   the debug UART transmitter as one framed byte stream. Owns the EBR read port and the
//   ZUART_Tx iEn/iData/oDone handshake; the top-level sequencer only issues start and waits for done.
//   Frame: SYNC0, SYNC1, CNT_H, CNT_L, {WORD_H, WORD_L} x count, CHKSUM.
// PARAMETERS
//   ADDR_W   10     EBR address width; addresses wrap modulo 2**ADDR_W
//   RD_LAT   1      EBR read latency in iClk cycles from oEBR_Rd_Addr to valid iEBR_Rd_Data (1..3)
//   SYNC0    8'hA5  first frame byte
//   SYNC1    8'h5A  second frame byte
// PORTS
//   iClk           in   1       system clock (48 MHz)
//   iRst_N         in   1       asynchronous, active-low reset
//   iStart         in   1       1-cycle pulse; starts a frame when idle
//   iBase_Addr     in   ADDR_W  first EBR word address, sampled on accepted iStart
//   iWord_Cnt      in   11      words to send, 0..1024, sampled on accepted iStart
//   oBusy          out  1       high from accepted iStart until the cycle oDone pulses
//   oDone          out  1       1-cycle pulse after CHKSUM byte is acknowledged
//   oEBR_Rd_En     out  1       EBR read enable / read clock enable
//   oEBR_Rd_Addr   out  ADDR_W  EBR read address
//   iEBR_Rd_Data   in   16      EBR read data
//   oTx_En         out  1       UART transmit request, level
//   oTx_Data       out  8       byte to transmit; stable while oTx_En high
//   iTx_Done       in   1       UART byte-complete pulse
// BEHAVIOUR
//   Reset values: oBusy=0, oDone=0, oEBR_Rd_En=0, oEBR_Rd_Addr=0, oTx_En=0, oTx_Data=0; FSM=IDLE.
//   All logic on posedge iClk only (read data sampled on rising edge, not falling edge).
//   States: IDLE -> HDR0 -> HDR1 -> CNTH -> CNTL -> [RD -> RDW -> TXH -> TXL]* -> SUM -> FIN -> IDLE.
//   IDLE: iStart=1 latches base, count, clears checksum/index, oBusy<=1, next HDR0. iStart while busy ignored.
//   Byte send (every TX state): oTx_En<=1, oTx_Data<=byte; hold both until iTx_Done=1; that cycle
//     oTx_En<=0; oTx_En then stays low >=1 full cycle (GAP) before next byte. iTx_Done seen while
//     oTx_En=0 is ignored.
//   CNT_H/CNT_L: {5'b0, iWord_Cnt} as 16 bits, high byte first.
//   After CNTL: if count==0 go straight to SUM (checksum byte 8'h00).
//   RD: oEBR_Rd_En<=1, oEBR_Rd_Addr<=(base+idx) mod 2**ADDR_W. RDW: wait RD_LAT cycles, capture
//     iEBR_Rd_Data into word register, oEBR_Rd_En<=0. TXH sends word[15:8], TXL sends word[7:0].
//   After TXL: idx+1; if idx==count go SUM else RD. Idx is 11 bits so count=1024 is legal
//     (full wrap, each address read exactly once).
//   Checksum: 8-bit sum mod 256 of all data bytes only (not sync/count), updated as each data byte
//     is acknowledged. SUM sends it.
//   FIN: oDone<=1 for exactly one cycle, oBusy<=0 same cycle, back to IDLE; iStart in FIN ignored.
//   Reset mid-frame: all outputs return to reset values asynchronously; partial frame abandoned.
//   Frame latency: (4 + 2*count + 1) UART byte times plus per-word (1+RD_LAT) + per-byte 1 gap cycle.
// TESTING
//   T1 base=0x004, cnt=2, EBR[4]=0x1987, EBR[5]=0x00FF -> bytes A5 5A 00 02 19 87 00 FF 9F, one oDone.
//   T2 cnt=0 -> bytes A5 5A 00 00 00; no oEBR_Rd_En pulse; oDone 1 cycle after last ack.
//   T3 base=0x3FF, cnt=2, EBR[0x3FF]=0x0102, EBR[0]=0x0304 -> read addrs 0x3FF then 0x000; sum 0x0A.
//   T4 UART model delays iTx_Done 0..40 cycles randomly; check oTx_Data stable while oTx_En=1 and
//      oTx_En low >=1 cycle between bytes; second iStart mid-frame -> no effect on byte stream.
//   T5 RD_LAT=2 with EBR model of latency 2, cnt=3 -> data bytes match memory, not stale words.
//   T6 assert iRst_N low during data byte 3 of cnt=4 frame -> oTx_En,oBusy=0 at once; new start
//      after release produces complete correct frame from A5.

Source files
------------

// File: rtl/ebr_uart_dumper.sv
// Streams a window of EBR words out of the UART as SYNC0 SYNC1 CNT_H CNT_L {W_H W_L}*n CHKSUM.
// Paced by iTx_Done: one byte in flight, at least one idle cycle between bytes, (1+RD_LAT)+1 cycles per word read.
module ebr_uart_dumper #(
  parameter int         ADDR_W = 10,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] SYNC0  = 8'hA5,
  parameter logic [7:0] SYNC1  = 8'h5A
) (
  input  logic              iClk,
  input  logic              iRst_N,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBase_Addr,
  input  logic [10:0]       iWord_Cnt,
  output logic              oBusy,
  output logic              oDone,
  output logic              oEBR_Rd_En,
  output logic [ADDR_W-1:0] oEBR_Rd_Addr,
  input  logic [15:0]       iEBR_Rd_Data,
  output logic              oTx_En,
  output logic [7:0]        oTx_Data,
  input  logic              iTx_Done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CNTH, S_CNTL, S_RD, S_RDW, S_TXH, S_TXL, S_SUM, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [10:0]         cnt_q, cnt_d;
  logic [10:0]         idx_q, idx_d;
  logic [7:0]          sum_q, sum_d;
  logic [15:0]         word_q, word_d;
  logic [1:0]          wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                is_tx;
  logic [7:0]          tx_byte;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    word_d    = word_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    is_tx     = 1'b0;
    tx_byte   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          base_d  = iBase_Addr;
          cnt_d   = iWord_Cnt;
          idx_d   = 11'd0;
          sum_d   = 8'h00;
          busy_d  = 1'b1;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin is_tx = 1'b1; tx_byte = SYNC0; end
      S_HDR1: begin is_tx = 1'b1; tx_byte = SYNC1; end
      S_CNTH: begin is_tx = 1'b1; tx_byte = {5'b0, cnt_q[10:8]}; end
      S_CNTL: begin is_tx = 1'b1; tx_byte = cnt_q[7:0]; end
      S_TXH:  begin is_tx = 1'b1; tx_byte = word_q[15:8]; end
      S_TXL:  begin is_tx = 1'b1; tx_byte = word_q[7:0]; end
      S_SUM:  begin is_tx = 1'b1; tx_byte = sum_q; end
      S_RD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = base_q + ADDR_W'(idx_q);
        wait_d    = 2'd0;
        state_d   = S_RDW;
      end
      // The address only reaches the EBR one edge after RD, so data is taken RD_LAT edges later still.
      S_RDW: begin
        if (wait_q == 2'(RD_LAT)) begin
          word_d  = iEBR_Rd_Data;
          rd_en_d = 1'b0;
          state_d = S_TXH;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (is_tx) begin
      if (!tx_en_q) begin
        tx_en_d   = 1'b1;
        tx_data_d = tx_byte;
      end else if (iTx_Done) begin
        tx_en_d = 1'b0;
        case (state_q)
          S_HDR0: state_d = S_HDR1;
          S_HDR1: state_d = S_CNTH;
          S_CNTH: state_d = S_CNTL;
          S_CNTL: state_d = (cnt_q == 11'd0) ? S_SUM : S_RD;
          S_TXH: begin
            sum_d   = sum_q + tx_byte;
            state_d = S_TXL;
          end
          S_TXL: begin
            sum_d   = sum_q + tx_byte;
            idx_d   = idx_q + 11'd1;
            state_d = ((idx_q + 11'd1) == cnt_q) ? S_SUM : S_RD;
          end
          S_SUM: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      word_q    <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      word_q    <= word_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oEBR_Rd_En   = rd_en_q;
  assign oEBR_Rd_Addr = rd_addr_q;
  assign oTx_En       = tx_en_q;
  assign oTx_Data     = tx_data_q;

endmodule
